// File: rtl/lsu_bus_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_if
//  Purpose  : Groups the EXU request/response handshake and the
//             request/grant memory bus of the load/store unit.
//  Modports : slave  - the LSU view. It receives EXU requests, returns
//                      responses and drives the memory bus.
//             master - the environment view (EXU plus memory).
//  Ports    : in_valid/in_ready/in_we/in_funct3/in_addr/in_wdata
//             out_valid/out_ready/out_rdata/out_err
//             mem_req/mem_gnt/mem_we/mem_addr/mem_wdata/mem_wstrb
//             mem_rvalid/mem_rdata
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // EXU request
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_we;
    logic [2:0]            in_funct3;
    logic [ADDR_W-1:0]     in_addr;
    logic [DATA_W-1:0]     in_wdata;
    // EXU response
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_rdata;
    logic                  out_err;
    // Memory bus
    logic                  mem_req;
    logic                  mem_gnt;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  in_valid, in_we, in_funct3, in_addr, in_wdata,
        input  out_ready,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready,
        output out_valid, out_rdata, out_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output in_valid, in_we, in_funct3, in_addr, in_wdata,
        output out_ready,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready,
        input  out_valid, out_rdata, out_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_ctrl
//  Purpose  : Multi-cycle load/store unit between the EXU and a
//             request/grant memory bus. It accepts one access per
//             valid/ready handshake and issues a lane-aligned bus request
//             with byte strobes. It returns sign/zero-extended load data,
//             or a store completion, with an error flag.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - lsu_bus_if.slave. It carries the EXU in_*/out_*
//                     handshake and the mem_* request/grant bus.
//  Params   : ADDR_W      byte address width
//             DATA_W      bus/register width, 32 or 64
//             TIMEOUT_CYC maximum cycles in REQ+WAIT before abort (>=2)
//  Config   : LSU_MISALIGN_TRAP_EN - when defined, a misaligned half, word
//             or dword access returns an error without a bus access. When
//             it is undefined, the low address bits are truncated to
//             natural alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  wire logic clk,
    input  wire logic rst_n,
    lsu_bus_if.slave  bus
);

    localparam int c_SW    = DATA_W / 8;
    localparam int c_LB    = $clog2(c_SW);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Access decode helpers
    // ------------------------------------------------------------------
    function automatic logic f_legal(input logic we, input logic [2:0] f3);
        logic l;
        if (we) begin
            l = (f3[2] == 1'b0) && ((f3[1:0] != 2'd3) || (DATA_W == 64));
        end else begin
            case (f3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: l = 1'b1;
                3'd3, 3'd6:                   l = (DATA_W == 64);
                default:                      l = 1'b0;
            endcase
        end
        return l;
    endfunction

    // Clears the offset bits below the access size (natural alignment).
    function automatic logic [c_LB-1:0] f_align_off(input logic [c_LB-1:0] off,
                                                    input logic [1:0]      size);
        logic [c_LB-1:0] m;
        m = '1;
        case (size)
            2'd0:    m = '1;
            2'd1:    m[0] = 1'b0;
            2'd2:    m[1:0] = 2'b00;
            default: m = '0;
        endcase
        return off & m;
    endfunction

    function automatic logic [c_SW-1:0] f_strb(input logic [c_LB-1:0] off,
                                               input logic [1:0]      size);
        logic [c_SW-1:0] base;
        base = '0;
        case (size)
            2'd0:    base[0]   = 1'b1;
            2'd1:    base[1:0] = 2'b11;
            2'd2:    base[3:0] = 4'hF;
            default: base      = '1;
        endcase
        return base << off;
    endfunction

    // Repeats the right-aligned store datum into every lane of its size.
    function automatic logic [DATA_W-1:0] f_repl(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        size);
        logic [DATA_W-1:0] r;
        r = d;
        for (int i = 0; i < c_SW; i++) begin
            case (size)
                2'd0:    r[i*8 +: 8] = d[7:0];
                2'd1:    r[i*8 +: 8] = d[(i % 2)*8 +: 8];
                2'd2:    r[i*8 +: 8] = d[(i % 4)*8 +: 8];
                default: r[i*8 +: 8] = d[i*8 +: 8];
            endcase
        end
        return r;
    endfunction

    // Right-aligns the addressed lane and extends it.
    // funct3[2] selects zero extension.
    function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] raw,
                                                   input logic [c_LB-1:0]   off,
                                                   input logic [2:0]        f3);
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] r;
        logic              ext;
        int                n;
        s = raw >> {off, 3'b000};
        case (f3[1:0])
            2'd0:    begin n = 8;      ext = s[7];        end
            2'd1:    begin n = 16;     ext = s[15];       end
            2'd2:    begin n = 32;     ext = s[31];       end
            default: begin n = DATA_W; ext = s[DATA_W-1]; end
        endcase
        ext = ext & ~f3[2];
        r = s;
        for (int b = 8; b < DATA_W; b++) begin
            if (b >= n) begin
                r[b] = ext;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode (valid only while IDLE)
    // ------------------------------------------------------------------
    logic [1:0]      w_size;
    logic [c_LB-1:0] w_off_in;
    logic [c_LB-1:0] w_off_al;
    logic            w_legal;
    logic            w_misalign;

    assign w_size   = bus.in_funct3[1:0];
    assign w_off_in = bus.in_addr[c_LB-1:0];
    assign w_off_al = f_align_off(w_off_in, w_size);
    assign w_legal  = f_legal(bus.in_we, bus.in_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (w_off_al != w_off_in);
`else
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state_q,     w_state_d;
    logic                r_we_q,        w_we_d;
    logic [2:0]          r_funct3_q,    w_funct3_d;
    logic [c_LB-1:0]     r_off_q,       w_off_d;
    logic [c_CNT_W-1:0]  r_cnt_q,       w_cnt_d;
    logic                r_out_valid_q, w_out_valid_d;
    logic [DATA_W-1:0]   r_out_rdata_q, w_out_rdata_d;
    logic                r_out_err_q,   w_out_err_d;
    logic                r_mem_req_q,   w_mem_req_d;
    logic                r_mem_we_q,    w_mem_we_d;
    logic [ADDR_W-1:0]   r_mem_addr_q,  w_mem_addr_d;
    logic [DATA_W-1:0]   r_mem_wdata_q, w_mem_wdata_d;
    logic [c_SW-1:0]     r_mem_wstrb_q, w_mem_wstrb_d;

    logic                w_timeout;
    logic [c_CNT_W-1:0]  w_cnt_inc;

    assign w_timeout = (r_cnt_q == c_CNT_LAST);
    // Saturates so a grant on the last REQ cycle leaves no spare budget in WAIT.
    assign w_cnt_inc = w_timeout ? r_cnt_q : r_cnt_q + 1'b1;

    always_comb begin
        w_state_d     = r_state_q;
        w_we_d        = r_we_q;
        w_funct3_d    = r_funct3_q;
        w_off_d       = r_off_q;
        w_cnt_d       = r_cnt_q;
        w_out_valid_d = r_out_valid_q;
        w_out_rdata_d = r_out_rdata_q;
        w_out_err_d   = r_out_err_q;
        w_mem_req_d   = r_mem_req_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_mem_wstrb_d = r_mem_wstrb_q;

        case (r_state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_we_d     = bus.in_we;
                    w_funct3_d = bus.in_funct3;
                    w_off_d    = w_off_al;
                    w_cnt_d    = '0;
                    if (!w_legal || w_misalign) begin
                        // Faulting access: respond at once without touching the bus.
                        w_state_d     = ST_RESP;
                        w_out_valid_d = 1'b1;
                        w_out_err_d   = 1'b1;
                        w_out_rdata_d = '0;
                    end else begin
                        w_state_d     = ST_REQ;
                        w_mem_req_d   = 1'b1;
                        w_mem_we_d    = bus.in_we;
                        w_mem_addr_d  = {bus.in_addr[ADDR_W-1:c_LB], {c_LB{1'b0}}};
                        w_mem_wdata_d = bus.in_we ? f_repl(bus.in_wdata, w_size) : '0;
                        w_mem_wstrb_d = bus.in_we ? f_strb(w_off_al, w_size) : '0;
                    end
                end
            end

            ST_REQ: begin
                if (bus.mem_gnt || w_timeout) begin
                    w_mem_req_d   = 1'b0;
                    w_mem_we_d    = 1'b0;
                    w_mem_addr_d  = '0;
                    w_mem_wdata_d = '0;
                    w_mem_wstrb_d = '0;
                end
                if (bus.mem_gnt) begin
                    // A grant on the timeout cycle still completes normally.
                    if (r_we_q) begin
                        w_state_d     = ST_RESP;
                        w_out_valid_d = 1'b1;
                        w_out_err_d   = 1'b0;
                        w_out_rdata_d = '0;
                    end else begin
                        w_state_d = ST_WAIT;
                        w_cnt_d   = w_cnt_inc;
                    end
                end else if (w_timeout) begin
                    w_state_d     = ST_RESP;
                    w_out_valid_d = 1'b1;
                    w_out_err_d   = 1'b1;
                    w_out_rdata_d = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_state_d     = ST_RESP;
                    w_out_valid_d = 1'b1;
                    w_out_err_d   = 1'b0;
                    w_out_rdata_d = f_extend(bus.mem_rdata, r_off_q, r_funct3_q);
                end else if (w_timeout) begin
                    w_state_d     = ST_RESP;
                    w_out_valid_d = 1'b1;
                    w_out_err_d   = 1'b1;
                    w_out_rdata_d = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            default: begin // ST_RESP
                if (bus.out_ready) begin
                    w_state_d     = ST_IDLE;
                    w_out_valid_d = 1'b0;
                    w_out_err_d   = 1'b0;
                    w_out_rdata_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_we_q        <= 1'b0;
            r_funct3_q    <= 3'd0;
            r_off_q       <= '0;
            r_cnt_q       <= '0;
            r_out_valid_q <= 1'b0;
            r_out_rdata_q <= '0;
            r_out_err_q   <= 1'b0;
            r_mem_req_q   <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_mem_wstrb_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_we_q        <= w_we_d;
            r_funct3_q    <= w_funct3_d;
            r_off_q       <= w_off_d;
            r_cnt_q       <= w_cnt_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_rdata_q <= w_out_rdata_d;
            r_out_err_q   <= w_out_err_d;
            r_mem_req_q   <= w_mem_req_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_mem_wstrb_q <= w_mem_wstrb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state_q == ST_IDLE);
    assign bus.out_valid = r_out_valid_q;
    assign bus.out_rdata = r_out_rdata_q;
    assign bus.out_err   = r_out_err_q;
    assign bus.mem_req   = r_mem_req_q;
    assign bus.mem_we    = r_mem_we_q;
    assign bus.mem_addr  = r_mem_addr_q;
    assign bus.mem_wdata = r_mem_wdata_q;
    assign bus.mem_wstrb = r_mem_wstrb_q;

endmodule
`default_nettype wire
